// File: rtl/mealy_seq_pkg.sv
// Shared types and defaults for the Mealy stream sequencer.
//   state_e    : sequencer FSM encoding (2 bits)
//   DATA_W_DEF : default frame width in bits
//   CNT_W_DEF  : default match counter width
package mealy_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mealy_seq_shreg.sv
// Loadable shift register with a direction select. It presents the next bit
// to be sent on head.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the register
//   load  : parallel load of d (takes priority over shift)
//   shift : advance one bit toward the head
//   dir   : 1 = head is bit W-1 (MSB first), 0 = head is bit 0 (LSB first)
//   d     : parallel load data
//   head  : current head bit
module mealy_seq_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         dir,
  input  logic [W-1:0] d,
  output logic         head
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  // NOTE: give every combinational output a default first so that no path
  // through the block leaves it unassigned; that is what stops a latch.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      sr_d = dir ? {sr_q[W-2:0], 1'b0} : {1'b0, sr_q[W-1:1]};
    end
  end

  assign head = dir ? sr_q[W-1] : sr_q[0];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

endmodule

// File: rtl/mealy_stream_sequencer.sv
// Frame sequencer for the Mealy sequence detector. It accepts a parallel frame
// on a valid/ready handshake and can pulse a detector clear first. It then
// shifts the frame out one bit per enabled cycle, samples the detector's Mealy
// output on each bit, and reports the match count and the per-bit match mask.
//   clk, rst              : clock; synchronous active-high reset
//   ena                   : global enable, low freezes all state
//   in_data/in_valid/in_ready : frame handshake
//   msb_first, cont_mode  : per-frame options, sampled at accept
//   det_bit/det_en/det_clr: drive to detector
//   det_match             : detector combinational Mealy output
//   busy, done            : status (done is a one-cycle pulse)
//   match_cnt, match_mask : results of last frame, held until next accept
module mealy_stream_sequencer
  import mealy_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              msb_first,
  input  logic              cont_mode,
  output logic              det_bit,
  output logic              det_en,
  output logic              det_clr,
  input  logic              det_match,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [DATA_W-1:0] match_mask
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              msb_first_q, msb_first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              load;
  logic              shift;
  logic              head;

  mealy_seq_shreg #(.W(DATA_W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .dir   (msb_first_q),
    .d     (in_data),
    .head  (head)
  );

  // Control outputs are decoded from the registered state. The only input
  // gating is by ena, plus rst on in_ready so that no frame is offered while
  // reset is held.
  assign in_ready   = (state_q == S_IDLE) && ena && !rst;
  assign det_en     = (state_q == S_SHIFT) && ena;
  assign det_clr    = (state_q == S_CLEAR) && ena;
  assign done       = (state_q == S_DONE) && ena;
  assign busy       = (state_q == S_CLEAR) || (state_q == S_SHIFT);
  assign det_bit    = (state_q == S_SHIFT) && head;
  assign match_cnt  = cnt_q;
  assign match_mask = mask_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    msb_first_d = msb_first_q;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    load        = 1'b0;
    shift       = 1'b0;

    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            load        = 1'b1;
            msb_first_d = msb_first;
            cnt_d       = '0;
            mask_d      = '0;
            idx_d       = '0;
            // cont_mode only steers this one transition, so it needs no flop.
            state_d     = cont_mode ? S_SHIFT : S_CLEAR;
          end
        end
        S_CLEAR: state_d = S_SHIFT;
        S_SHIFT: begin
          shift = 1'b1;
          // det_match is the detector's Mealy response to this cycle's det_bit.
          if (det_match) begin
            cnt_d         = cnt_q + CNT_W'(1);
            mask_d[idx_q] = 1'b1;
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      msb_first_q <= 1'b0;
      cnt_q       <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      msb_first_q <= msb_first_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
    end
  end

endmodule

// File: tb/tb_mealy_stream_sequencer.sv
// Directed bench for mealy_stream_sequencer. It contains a behavioural
// overlapping "101" Mealy detector.
module tb_mealy_stream_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       msb_first;
  logic       cont_mode;
  logic       det_bit;
  logic       det_en;
  logic       det_clr;
  logic       det_match;
  logic       busy;
  logic       done;
  logic [3:0] match_cnt;
  logic [7:0] match_mask;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mealy_stream_sequencer #(.DATA_W(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .msb_first  (msb_first),
    .cont_mode  (cont_mode),
    .det_bit    (det_bit),
    .det_en     (det_en),
    .det_clr    (det_clr),
    .det_match  (det_match),
    .busy       (busy),
    .done       (done),
    .match_cnt  (match_cnt),
    .match_mask (match_mask)
  );

  // Overlapping "101" detector: 0 = nothing, 1 = seen "1", 2 = seen "10".
  logic [1:0] dstate = 2'd0;
  assign det_match = (dstate == 2'd2) && det_bit;

  always @(posedge clk) begin
    if (det_clr) begin
      dstate <= 2'd0;
    end else if (det_en) begin
      case (dstate)
        2'd0:    dstate <= det_bit ? 2'd1 : 2'd0;
        2'd1:    dstate <= det_bit ? 2'd1 : 2'd2;
        default: dstate <= det_bit ? 2'd1 : 2'd0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one frame and run it to completion. ebits lists the shifted bits in
  // order, the first shifted bit at bit 7. pause_after >= 0 drops ena for
  // pause_len cycles once that many bits have been shifted.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic msb,
                           input logic cont, input logic [3:0] ecnt, input logic [7:0] emask,
                           input logic [7:0] ebits, input int pause_after, input int pause_len,
                           input bit hold_valid);
    int lat = 0, en_seen = 0, clr_seen = 0, rdy_seen = 0, en_in_pause = 0, pause_left = 0;
    bit got_done = 0, paused = 0;
    logic [7:0] bits = '0;
    @(posedge clk); #1;
    in_data = data; msb_first = msb; cont_mode = cont; in_valid = 1'b1; ena = 1'b1;
    @(negedge clk);
    check({tag, ".ready_at_offer"}, in_ready, 1);
    @(posedge clk); #1;
    // Options are sampled only at accept, so scramble them from here on.
    if (!hold_valid) in_valid = 1'b0;
    in_data = ~data; msb_first = ~msb; cont_mode = ~cont;
    for (int c = 0; c < 40 && !got_done; c++) begin
      if (pause_left > 0) begin
        ena = 1'b0; pause_left--;
      end else begin
        ena = 1'b1;
      end
      @(negedge clk);
      lat++;
      if (det_en) begin
        en_seen++;
        bits = {bits[6:0], det_bit};
      end
      if (!ena && det_en) en_in_pause++;
      if (det_clr) clr_seen++;
      if (in_ready) rdy_seen++;
      if (done) begin
        got_done = 1;
      end else begin
        if (!paused && en_seen == pause_after) begin
          paused = 1; pause_left = pause_len;
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    check({tag, ".done_seen"}, got_done, 1);
    check({tag, ".latency"}, lat, (cont ? 9 : 10) + pause_len);
    check({tag, ".match_cnt"}, match_cnt, ecnt);
    check({tag, ".match_mask"}, match_mask, emask);
    check({tag, ".det_en_pulses"}, en_seen, 8);
    check({tag, ".det_clr_pulses"}, clr_seen, cont ? 0 : 1);
    check({tag, ".bit_order"}, bits, ebits);
    check({tag, ".ready_while_busy"}, rdy_seen, 0);
    if (pause_len > 0) check({tag, ".det_en_in_pause"}, en_in_pause, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, ".done_one_cycle"}, done, 0);
    check({tag, ".idle_ready"}, in_ready, 1);
    check({tag, ".cnt_held"}, match_cnt, ecnt);
    check({tag, ".mask_held"}, match_mask, emask);
  endtask

  initial begin
    int en_seen;
    int lat;
    bit seen_done;
    rst = 1'b1; ena = 1'b1; in_data = '0; in_valid = 1'b0;
    msb_first = 1'b0; cont_mode = 1'b0;

    // Reset held for two cycles with ena high: in_ready must still be low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.in_ready", in_ready, 0);
    check("reset.busy", busy, 0);
    check("reset.done", done, 0);
    check("reset.match_cnt", match_cnt, 0);
    check("reset.match_mask", match_mask, 0);
    check("reset.det_en", det_en, 0);
    check("reset.det_clr", det_clr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset.release_ready", in_ready, 1);

    // MSB-first 0xAA, cleared detector: matches on shifted bits 2, 4 and 6.
    run_frame("aa_msb", 8'hAA, 1'b1, 1'b0, 4'd3, 8'h54, 8'hAA, -1, 0, 1'b0);

    // Continuous mode: the trailing '1' of 0x01 combines with "01" of 0x40.
    run_frame("cont_f1", 8'h01, 1'b1, 1'b1, 4'd0, 8'h00, 8'h01, -1, 0, 1'b0);
    run_frame("cont_f2", 8'h40, 1'b1, 1'b1, 4'd1, 8'h02, 8'h40, -1, 0, 1'b0);
    // The same frames with clears in between give no match in frame 2.
    run_frame("clr_f1", 8'h01, 1'b1, 1'b0, 4'd0, 8'h00, 8'h01, -1, 0, 1'b0);
    run_frame("clr_f2", 8'h40, 1'b1, 1'b0, 4'd0, 8'h00, 8'h40, -1, 0, 1'b0);

    // LSB-first 0x05: bits 1,0,1,0,0,0,0,0.
    run_frame("lsb_05", 8'h05, 1'b0, 1'b0, 4'd1, 8'h04, 8'hA0, -1, 0, 1'b0);

    // Three-cycle pause after the 4th bit.
    run_frame("pause", 8'hAA, 1'b1, 1'b0, 4'd3, 8'h54, 8'hAA, 4, 3, 1'b0);

    // Reset asserted during the 5th shifted bit.
    @(posedge clk); #1;
    in_data = 8'hAA; msb_first = 1'b1; cont_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    en_seen = 0;
    for (int c = 0; c < 20 && en_seen < 4; c++) begin
      @(negedge clk);
      if (det_en) en_seen++;
      if (en_seen < 4) begin
        @(posedge clk); #1;
      end
    end
    check("midrst.reached_bit4", en_seen, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst.busy_before_edge", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst.in_ready", in_ready, 0);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.det_en", det_en, 0);
    check("midrst.det_clr", det_clr, 0);
    check("midrst.det_bit", det_bit, 0);
    check("midrst.match_cnt", match_cnt, 0);
    check("midrst.match_mask", match_mask, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen_done = 0;
    lat = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1;
      if (busy) lat++;
    end
    check("midrst.no_done", seen_done, 0);
    check("midrst.stays_idle", lat, 0);

    // A frame with in_valid held high while busy must be accepted only once.
    run_frame("after_rst", 8'hAA, 1'b1, 1'b0, 4'd3, 8'h54, 8'hAA, -1, 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
